// File: rtl/fft256_pkg.sv
// Shared sizes, FSM state type and butterfly address helper for the 256-point in-place FFT sequencer.
// Pure definitions: no latency and no backpressure.
package fft256_pkg;

  localparam int N            = 256;
  localparam int LOG2N        = 8;
  localparam int BF_PER_STAGE = 128;
  localparam int TW_ADDR_W    = 10;
  localparam int DATA_ADDR_W  = 8;
  localparam int STAGE_W      = 3;
  localparam int BF_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [DATA_ADDR_W-1:0] a;
    logic [DATA_ADDR_W-1:0] b;
  } bf_pair_t;

  // A is bf_idx with a zero inserted at bit position 'stage'; B sets that bit.
  function automatic bf_pair_t bf_addr(input logic [STAGE_W-1:0] stage,
                                       input logic [BF_W-1:0]    bf_idx);
    logic [DATA_ADDR_W-1:0] b_ext;
    logic [DATA_ADDR_W-1:0] low_mask;
    bf_pair_t               pair;
    b_ext    = {1'b0, bf_idx};
    low_mask = (8'd1 << stage) - 8'd1;
    pair.a   = ((b_ext >> stage) << ({1'b0, stage} + 4'd1)) | (b_ext & low_mask);
    pair.b   = pair.a | (8'd1 << stage);
    return pair;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register, DEPTH cycles of latency, advances every cycle (no backpressure).
// Asynchronous active-low reset clears every tap to zero.
module fft_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft256_stage_sequencer.sv
// Sequences 8 stages x 128 butterflies: read/twiddle issue now, tw_valid +ROM_LAT, write-back +ROM_LAT+BF_LAT.
// ready_in_i low stalls issue only; delay lines always advance. FFT_INVERSE_EN adds inverse_i / tw_conj_o.
module fft256_stage_sequencer
  import fft256_pkg::*;
#(
  parameter int ROM_LAT   = 1,
  parameter int BF_LAT    = 4,
  parameter int DRAIN_CYC = ROM_LAT + BF_LAT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   ready_in_i,
`ifdef FFT_INVERSE_EN
  input  logic                   inverse_i,
  output logic                   tw_conj_o,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic [STAGE_W-1:0]     stage_o,
  output logic [DATA_ADDR_W-1:0] rd_addr_a_o,
  output logic [DATA_ADDR_W-1:0] rd_addr_b_o,
  output logic [TW_ADDR_W-1:0]   tw_addr_o,
  output logic                   rd_en_o,
  output logic                   tw_valid_o,
  output logic [DATA_ADDR_W-1:0] wr_addr_a_o,
  output logic [DATA_ADDR_W-1:0] wr_addr_b_o,
  output logic                   wr_en_o
);

  localparam int WB_LAT  = ROM_LAT + BF_LAT;
  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int WB_W    = 1 + 2 * DATA_ADDR_W;

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG2N - 1);
  localparam logic [BF_W-1:0]    LAST_BF    = BF_W'(BF_PER_STAGE - 1);

  seq_state_e         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BF_W-1:0]    bf_q, bf_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               drain_last;

  logic                   rd_en;
  logic [DATA_ADDR_W-1:0] rd_a;
  logic [DATA_ADDR_W-1:0] rd_b;
  logic [TW_ADDR_W-1:0]   tw_addr;
  bf_pair_t               pair;
  logic [WB_W-1:0]        wb_dout;

  assign drain_last = (drain_q == DRAIN_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_ISSUE;
      ST_ISSUE:  if (ready_in_i && (bf_q == LAST_BF)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_last) begin
          state_d = (stage_q == LAST_STAGE) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    rd_en  = 1'b0;
    unique case (state_q)
      ST_ISSUE: begin
        busy_o = 1'b1;
        rd_en  = ready_in_i;
      end
      ST_DRAIN:  busy_o = 1'b1;
      ST_FINISH: done_o = 1'b1;
      default: ;
    endcase
  end

  // Stage / butterfly / drain counters follow the FSM transitions above.
  always_comb begin
    stage_d = stage_q;
    bf_d    = bf_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          stage_d = '0;
          bf_d    = '0;
          drain_d = '0;
        end
      end
      ST_ISSUE: begin
        drain_d = '0;
        if (ready_in_i) bf_d = bf_q + 1'b1;
      end
      ST_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_last) begin
          drain_d = '0;
          bf_d    = '0;
          if (stage_q != LAST_STAGE) stage_d = stage_q + 1'b1;
        end
      end
      ST_FINISH: stage_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stage_q <= '0;
      bf_q    <= '0;
      drain_q <= '0;
    end else begin
      stage_q <= stage_d;
      bf_q    <= bf_d;
      drain_q <= drain_d;
    end
  end

  // Addresses are zeroed on bubbles so idle and stalled cycles are deterministic.
  always_comb begin
    pair    = bf_addr(stage_q, bf_q);
    rd_a    = rd_en ? pair.a : '0;
    rd_b    = rd_en ? pair.b : '0;
    tw_addr = rd_en ? {stage_q, bf_q} : '0;
  end

  assign stage_o     = stage_q;
  assign rd_en_o     = rd_en;
  assign rd_addr_a_o = rd_a;
  assign rd_addr_b_o = rd_b;
  assign tw_addr_o   = tw_addr;

`ifdef FFT_INVERSE_EN
  logic       inverse_q;
  logic [1:0] tw_dout;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inverse_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      inverse_q <= inverse_i;
    end
  end

  fft_delay_line #(.DEPTH(ROM_LAT), .WIDTH(2)) u_tw_dly (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din_i   ({rd_en, rd_en & inverse_q}),
    .dout_o  (tw_dout)
  );

  assign tw_valid_o = tw_dout[1];
  assign tw_conj_o  = tw_dout[0];
`else
  fft_delay_line #(.DEPTH(ROM_LAT), .WIDTH(1)) u_tw_dly (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din_i   (rd_en),
    .dout_o  (tw_valid_o)
  );
`endif

  fft_delay_line #(.DEPTH(WB_LAT), .WIDTH(WB_W)) u_wb_dly (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din_i   ({rd_en, rd_a, rd_b}),
    .dout_o  (wb_dout)
  );

  assign wr_en_o     = wb_dout[WB_W-1];
  assign wr_addr_a_o = wb_dout[2*DATA_ADDR_W-1:DATA_ADDR_W];
  assign wr_addr_b_o = wb_dout[DATA_ADDR_W-1:0];

endmodule

// File: tb/tb_fft256_stage_sequencer.sv
// Scoreboard bench for fft256_stage_sequencer: issue-side model queues expected twiddle/write-back events.
// Optional inverse checks compile in with FFT_INVERSE_EN.
module tb_fft256_stage_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b1;
  logic       start_i = 1'b0;
  logic       ready_in_i = 1'b1;
  logic       busy_o, done_o, rd_en_o, tw_valid_o, wr_en_o;
  logic [2:0] stage_o;
  logic [7:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic [9:0] tw_addr_o;
`ifdef FFT_INVERSE_EN
  logic       inverse_i = 1'b0;
  logic       tw_conj_o;
`endif

  fft256_stage_sequencer dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .ready_in_i  (ready_in_i),
`ifdef FFT_INVERSE_EN
    .inverse_i   (inverse_i),
    .tw_conj_o   (tw_conj_o),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .stage_o     (stage_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .tw_addr_o   (tw_addr_o),
    .rd_en_o     (rd_en_o),
    .tw_valid_o  (tw_valid_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o),
    .wr_en_o     (wr_en_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { int due; bit conj; } tw_exp_t;
  typedef struct { int due; int a; int b; } wr_exp_t;

  tw_exp_t tw_q[$];
  wr_exp_t wr_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;
  bit inv_model = 1'b0;
  int exp_s, exp_b, rd_cnt, wr_cnt, done_cnt;
  int t_start, first_rd_edge, done_edge, last_wr_edge;
  bit cov [8][256];

  int m_span, m_grp, m_pos, m_a, m_b, edge_n;
  bit tw_due, wr_due;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Edge numbering: values seen at a negedge are sampled by posedge number cyc+1.
  always @(negedge clk_i) begin
    if (mon_en) begin
      edge_n = cyc + 1;
      if (rd_en_o) begin
        if (exp_s < 8) begin
          m_span = 1 << exp_s;
          m_grp  = exp_b / m_span;
          m_pos  = exp_b % m_span;
          m_a    = m_grp * 2 * m_span + m_pos;
          m_b    = m_a + m_span;
          chk("rd_addr_a", rd_addr_a_o, m_a);
          chk("rd_addr_b", rd_addr_b_o, m_b);
          chk("tw_addr", tw_addr_o, exp_s * 128 + exp_b);
          chk("stage", stage_o, exp_s);
          if (exp_s == 0 && exp_b == 0) begin
            chk("s0b0_a", rd_addr_a_o, 0);
            chk("s0b0_b", rd_addr_b_o, 1);
            chk("s0b0_tw", tw_addr_o, 0);
          end
          if (exp_s == 3 && exp_b == 13) begin
            chk("s3b13_a", rd_addr_a_o, 21);
            chk("s3b13_b", rd_addr_b_o, 29);
            chk("s3b13_tw", tw_addr_o, 397);
          end
          if (exp_s == 7 && exp_b == 127) begin
            chk("s7b127_a", rd_addr_a_o, 127);
            chk("s7b127_b", rd_addr_b_o, 255);
            chk("s7b127_tw", tw_addr_o, 1023);
          end
          chk("cov_dup_a", cov[exp_s][m_a], 0);
          chk("cov_dup_b", cov[exp_s][m_b], 0);
          cov[exp_s][m_a] = 1'b1;
          cov[exp_s][m_b] = 1'b1;
          tw_q.push_back('{due: edge_n + 1, conj: inv_model});
          wr_q.push_back('{due: edge_n + 5, a: m_a, b: m_b});
          if (first_rd_edge < 0) first_rd_edge = edge_n;
          exp_b++;
          if (exp_b == 128) begin
            exp_b = 0;
            exp_s++;
          end
        end else begin
          chk("extra_rd_en", 1, 0);
        end
        rd_cnt++;
      end

      tw_due = (tw_q.size() > 0) && (tw_q[0].due == edge_n);
      chk("tw_valid", tw_valid_o, tw_due);
`ifdef FFT_INVERSE_EN
      chk("tw_conj", tw_conj_o, tw_due ? tw_q[0].conj : 1'b0);
`endif
      if (tw_due) void'(tw_q.pop_front());

      wr_due = (wr_q.size() > 0) && (wr_q[0].due == edge_n);
      chk("wr_en", wr_en_o, wr_due);
      if (wr_due) begin
        chk("wr_addr_a", wr_addr_a_o, wr_q[0].a);
        chk("wr_addr_b", wr_addr_b_o, wr_q[0].b);
        void'(wr_q.pop_front());
      end
      if (wr_en_o) begin
        wr_cnt++;
        last_wr_edge = edge_n;
      end

      if (done_o) begin
        done_cnt++;
        done_edge = edge_n;
        chk("wr_before_done", last_wr_edge < edge_n, 1);
      end
    end
  end

  task automatic clear_model(input bit inv);
    tw_q.delete();
    wr_q.delete();
    exp_s = 0; exp_b = 0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    first_rd_edge = -1; done_edge = -1; last_wr_edge = -1;
    inv_model = inv;
    for (int s = 0; s < 8; s++)
      for (int a = 0; a < 256; a++)
        cov[s][a] = 1'b0;
  endtask

  task automatic kick_start(input bit inv);
    @(posedge clk_i); #1;
    start_i = 1'b1;
`ifdef FFT_INVERSE_EN
    inverse_i = inv;
`endif
    t_start = cyc + 1;
  endtask

  task automatic run_fft(input int stall_pct, input bit inv, input bit timing_chk);
    int budget;
    int hits;
    clear_model(inv);
    mon_en = 1'b1;
    kick_start(inv);
    budget = 5000;
    while (done_cnt == 0 && budget > 0) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
`ifdef FFT_INVERSE_EN
      inverse_i = ~inv;
`endif
      ready_in_i = ($urandom_range(0, 99) >= stall_pct);
      if (stall_pct > 0 && busy_o && $urandom_range(0, 15) == 0) start_i = 1'b1;
      if (timing_chk && cyc == t_start + 1064) start_i = 1'b1;
      budget--;
    end
    chk("done_seen", done_cnt > 0, 1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    ready_in_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("busy_after_done", busy_o, 0);
    chk("rd_en_count", rd_cnt, 1024);
    chk("wr_en_count", wr_cnt, 1024);
    chk("done_count", done_cnt, 1);
    chk("tw_q_empty", tw_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    for (int s = 0; s < 8; s++) begin
      hits = 0;
      for (int a = 0; a < 256; a++) hits += cov[s][a];
      chk($sformatf("cover_stage%0d", s), hits, 256);
    end
    if (timing_chk) begin
      chk("first_rd_latency", first_rd_edge - t_start, 1);
      chk("done_latency", done_edge - t_start, 1065);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_stage"}, stage_o, 0);
    chk({tag, "_rd"}, {rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o}, 0);
    chk({tag, "_tw_valid"}, tw_valid_o, 0);
    chk({tag, "_wr"}, {wr_en_o, wr_addr_a_o, wr_addr_b_o}, 0);
  endtask

  initial begin
    int budget;
    #2 rst_n_i = 1'b0;
    #10;
    chk_all_zero("reset");
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);

    run_fft(0, 1'b0, 1'b1);
    run_fft(40, 1'b0, 1'b0);

    clear_model(1'b0);
    mon_en = 1'b1;
    kick_start(1'b0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    budget = 3000;
    while (stage_o != 3'd4 && budget > 0) begin
      @(posedge clk_i); #1;
      ready_in_i = ($urandom_range(0, 99) >= 20);
      budget--;
    end
    chk("reach_stage4", stage_o, 4);
    repeat (30) @(posedge clk_i);
    #2;
    mon_en = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) @(posedge clk_i);
    #1;
    ready_in_i = 1'b1;
    rst_n_i = 1'b1;
    clear_model(1'b0);
    mon_en = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", busy_o, 0);
    chk("abort_no_rd", rd_cnt, 0);

    run_fft(0, 1'b0, 1'b1);
`ifdef FFT_INVERSE_EN
    run_fft(30, 1'b1, 1'b0);
    run_fft(0, 1'b0, 1'b0);
`endif
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/fft256_stage_sequencer.md
Name: fft256_stage_sequencer

Overview:
Controller that sequences the in-place radix-2 DIT 256-point FFT over 8 stages × 128 butterflies. It generates the data-RAM read address pair, the twiddle ROM address ({stage, butterfly}), and the delayed write-back address pair and enable. Outputs are aligned to the twiddle ROM's registered read and the butterfly pipeline latency. It sits between the top-level FFT control and the data RAM / twiddle ROM / butterfly datapath.

Parameters:
ROM_LAT, 1, twiddle ROM read latency in cycles (the ROM is registered, 1 cycle)
BF_LAT, 4, butterfly datapath latency in cycles from operand/twiddle valid to result
DRAIN_CYC, ROM_LAT+BF_LAT, inter-stage gap so the previous stage's writes complete before the next stage reads

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begin a transform (ignored while busy)
ready_in  in  1  datapath may accept an issue this cycle; low = stall issue
busy  out  1  transform in progress
done  out  1  one-cycle pulse at transform completion
stage  out  3  current stage 0..7
rd_addr_a  out  8  data RAM read address, upper-leg-free operand A
rd_addr_b  out  8  data RAM read address, operand B
tw_addr  out  10  twiddle ROM address = stage*128 + bf_idx
rd_en  out  1  issue strobe for rd_addr_a/b and tw_addr
tw_valid  out  1  rd_en delayed ROM_LAT cycles; ROM dout valid for this butterfly
wr_addr_a  out  8  rd_addr_a delayed ROM_LAT+BF_LAT cycles
wr_addr_b  out  8  rd_addr_b delayed ROM_LAT+BF_LAT cycles
wr_en  out  1  rd_en delayed ROM_LAT+BF_LAT cycles

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; delay lines cleared. Reset mid-transform aborts with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 → ISSUE; stage=0, bf_idx=0, busy=1 from the next cycle.
- ISSUE: each cycle with ready_in=1: rd_en=1; addresses computed from (s=stage, b=bf_idx); bf_idx increments. ready_in=0: rd_en=0 and counters hold. After issuing bf_idx=127 → DRAIN.
- Address rule: span=2^s, grp=b>>s, pos=b&(span-1), rd_addr_a=grp*2*span+pos, rd_addr_b=rd_addr_a+span (all 8-bit, no overflow by construction). tw_addr={s[2:0], b[6:0]}.
- DRAIN: counter runs DRAIN_CYC cycles, ignoring ready_in. At expiry: stage<7 → stage+1, bf_idx=0, ISSUE; stage=7 → FINISH.
- FINISH: done=1 for one cycle, busy=0, → IDLE. A start arriving in the FINISH cycle is ignored.
- Delay lines are shift registers that advance every cycle, independent of stall. Stalls produce bubbles (valid=0); addresses with valid=0 are don't-care but deterministic.
- Timing with ready_in held high: first rd_en in the cycle after start is sampled; each stage takes 128+DRAIN_CYC cycles; done asserts 8*(128+DRAIN_CYC)+1 cycles after start is sampled (1065 with defaults).
- The last wr_en occurs at least 1 cycle before done.

Optional Feature:
FFT_INVERSE_EN: adds input inverse (1 bit, sampled with an accepted start and held for the whole transform) and output tw_conj (1 bit, aligned with tw_valid). tw_conj=inverse when tw_valid=1, else 0; the datapath negates the twiddle imaginary part when tw_conj=1. Without the macro, neither port exists and forward FFT is implied.

Decomposition:
- Shared package fft256_pkg holds: N=256, LOG2N=8, BF_PER_STAGE=128, TW_ADDR_W=10, DATA_ADDR_W=8, the FSM state enum, and a function bf_addr(stage, bf_idx) returning the A/B address pair.
- One sub-module: fft_delay_line (parameterised DEPTH and WIDTH, async active-low reset to 0), instantiated for tw_valid/tw_conj and for the {wr_en, wr_addr_a, wr_addr_b} bundle.

Test Plan:
- Reset then start, ready_in=1 → stage0 b=0: rd_addr_a=0, rd_addr_b=1, tw_addr=0; tw_valid 1 cycle after rd_en; wr_en 5 cycles after rd_en.
- Stage 3, b=13 → rd_addr_a=21, rd_addr_b=29, tw_addr=397. Stage 7, b=127 → rd_addr_a=127, rd_addr_b=255, tw_addr=1023.
- Full run with ready_in=1 → exactly 1024 rd_en and 1024 wr_en pulses; done 1065 cycles after start; each stage covers every address 0..255 exactly once across A and B.
- ready_in toggled pseudo-randomly → same address sequence as the unstalled run with bubbles inserted; wr_en count is 1024; start pulses while busy are ignored.
- rst_n asserted mid-stage 4 → all outputs 0 asynchronously, no done; a new start afterwards runs a clean transform from stage 0.
- FFT_INVERSE_EN defined, start with inverse=1 → tw_conj=1 on every tw_valid; with inverse=0 → tw_conj is always 0.
